// File: rtl/count_mon_pkg.sv
// Shared types for the count event monitor.
//   evt_type_t  : event classification carried through the event FIFO
//   mon_state_t : monitor tracking state
package count_mon_pkg;

    typedef enum logic [1:0] {
        WRAP_UP    = 2'd0,
        WRAP_DOWN  = 2'd1,
        DIR_CHANGE = 2'd2,
        ILLEGAL    = 2'd3
    } evt_type_t;

    typedef enum logic [1:0] {
        INIT,   // no previous sample yet
        ARMED,  // previous sample held, direction unknown
        TRACK   // previous sample and direction known
    } mon_state_t;

endpackage

// File: rtl/count_event_monitor_if.sv
// Event stream between the monitor (master) and its consumer (slave).
//   evt_valid : FIFO head holds an event
//   evt_ready : consumer accepts the head event
//   evt_type  : head event type
//   evt_value : count value that caused the head event
interface count_event_monitor_if
    import count_mon_pkg::*;
#(
    parameter int N = 4
);
    logic          evt_valid;
    logic          evt_ready;
    evt_type_t     evt_type;
    logic [N-1:0]  evt_value;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_value,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_value,
        output evt_ready
    );
endinterface

// File: rtl/count_evt_fifo.sv
// First-word-fall-through FIFO holding monitor events.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless popping
//   pop        : read request; ignored when empty
//   dout       : head entry, valid while empty is low
//   full/empty : occupancy flags
module count_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO is taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/count_event_monitor.sv
// Watches an up/down looping counter (0..MAX_VALUE) and reports wraps,
// direction changes and illegal steps through an event FIFO.
//   clk, reset  : clock, asynchronous active-high reset
//   count       : sampled counter value
//   evt         : event stream (valid/ready/type/value), master side
//   wrap_up_cnt : saturating count of WRAP_UP detections
//   wrap_dn_cnt : saturating count of WRAP_DOWN detections
//   overflow    : sticky, an event was dropped on a full FIFO
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_VALUE = 10,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            count,
    count_event_monitor_if.master   evt,
    output logic [7:0]              wrap_up_cnt,
    output logic [7:0]              wrap_dn_cnt,
    output logic                    overflow
);
    mon_state_t   state;
    mon_state_t   state_next;
    logic [N-1:0] prev;
    logic         dir_up;
    logic         dir_up_next;

    logic         ev_push;
    evt_type_t    ev_type;

    // One extra bit so prev+1 / prev-1 never alias.
    logic [N:0]   prev_x;
    logic [N:0]   count_x;
    logic [N:0]   max_x;
    logic         is_up;
    logic         is_dn;
    logic         is_wrap_up;
    logic         is_wrap_dn;
    logic         step_up;
    logic         step_dn;
    logic         legal;

    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [N+1:0] fifo_dout;

    assign prev_x  = {1'b0, prev};
    assign count_x = {1'b0, count};
    assign max_x   = (N+1)'(MAX_VALUE);

    assign is_up      = (prev_x < max_x) && (count_x == prev_x + 1'b1);
    assign is_dn      = (prev_x != '0) && (count_x == prev_x - 1'b1);
    assign is_wrap_up = (prev_x == max_x) && (count_x == '0);
    assign is_wrap_dn = (prev_x == '0) && (count_x == max_x);
    assign step_up    = is_up || is_wrap_up;
    assign step_dn    = is_dn || is_wrap_dn;
    assign legal      = step_up || step_dn;

    // Next state, direction and event; priority ILLEGAL > wrap > DIR_CHANGE.
    always_comb begin
        state_next  = state;
        dir_up_next = dir_up;
        ev_push     = 1'b0;
        ev_type     = ILLEGAL;
        case (state)
            INIT: begin
                state_next = ARMED;
            end
            ARMED, TRACK: begin
                if (!legal) begin
                    ev_push    = 1'b1;
                    ev_type    = ILLEGAL;
                    state_next = ARMED;
                end else begin
                    state_next  = TRACK;
                    dir_up_next = step_up;
                    if (is_wrap_up) begin
                        ev_push = 1'b1;
                        ev_type = WRAP_UP;
                    end else if (is_wrap_dn) begin
                        ev_push = 1'b1;
                        ev_type = WRAP_DOWN;
                    end else if (state == TRACK && step_up != dir_up) begin
                        ev_push = 1'b1;
                        ev_type = DIR_CHANGE;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= INIT;
            prev   <= '0;
            dir_up <= 1'b1;
        end else begin
            state  <= state_next;
            prev   <= count;
            dir_up <= dir_up_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_up_cnt <= '0;
            wrap_dn_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            if (state != INIT && is_wrap_up && wrap_up_cnt != '1)
                wrap_up_cnt <= wrap_up_cnt + 1'b1;
            if (state != INIT && is_wrap_dn && wrap_dn_cnt != '1)
                wrap_dn_cnt <= wrap_dn_cnt + 1'b1;
            if (ev_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
        end
    end

    assign fifo_pop = evt.evt_valid && evt.evt_ready;

    count_evt_fifo #(
        .WIDTH (N + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev_push),
        .din   ({ev_type, count}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_type  = evt_type_t'(fifo_dout[N+1:N]);
    assign evt.evt_value = fifo_dout[N-1:0];
endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor (N=4, MAX_VALUE=10, DEPTH=4).
module tb_count_event_monitor;
    import count_mon_pkg::*;

    localparam int M = 10;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic [7:0] wrap_up_cnt;
    logic [7:0] wrap_dn_cnt;
    logic       overflow;

    count_event_monitor_if #(.N(4)) evt_if ();

    count_event_monitor #(
        .N         (4),
        .MAX_VALUE (M),
        .DEPTH     (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .evt         (evt_if),
        .wrap_up_cnt (wrap_up_cnt),
        .wrap_dn_cnt (wrap_dn_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: events as a bounded queue, steps classified by
    // modular distance on the 0..M ring.
    int q_type[$];
    int q_val[$];
    int m_prev;
    bit m_have;
    bit m_known;
    bit m_up;
    int m_wu;
    int m_wd;
    bit m_ov;
    int n_popped;
    int cval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_type.delete();
        q_val.delete();
        m_prev = 0; m_have = 0; m_known = 0; m_up = 1;
        m_wu = 0; m_wd = 0; m_ov = 0; n_popped = 0; cval = 0;
    endtask

    task automatic model_edge(input int c, input bit r);
        bit pop, ev, up, dn;
        int et, d;
        pop = (q_type.size() > 0) && r;
        ev = 0; et = 0; up = 0; dn = 0;
        if (!m_have) begin
            m_have = 1;
            m_known = 0;
        end else begin
            if (c <= M && m_prev <= M) begin
                d  = (c - m_prev + M + 1) % (M + 1);
                up = (d == 1);
                dn = (d == M);
            end
            if (!up && !dn) begin
                ev = 1; et = 3; m_known = 0;
            end else begin
                if (up && c == 0) begin
                    ev = 1; et = 0; m_wu = (m_wu < 255) ? m_wu + 1 : 255;
                end else if (dn && c == M) begin
                    ev = 1; et = 1; m_wd = (m_wd < 255) ? m_wd + 1 : 255;
                end else if (m_known && m_up != up) begin
                    ev = 1; et = 2;
                end
                m_known = 1;
                m_up = up;
            end
        end
        m_prev = c;
        if (pop) begin
            void'(q_type.pop_front());
            void'(q_val.pop_front());
            n_popped++;
        end
        if (ev) begin
            if (q_type.size() < D) begin
                q_type.push_back(et);
                q_val.push_back(c);
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("evt_valid", evt_if.evt_valid, q_type.size() > 0);
        if (q_type.size() > 0) begin
            chk("evt_type", evt_if.evt_type, q_type[0]);
            chk("evt_value", evt_if.evt_value, q_val[0]);
        end
        chk("wrap_up_cnt", wrap_up_cnt, m_wu);
        chk("wrap_dn_cnt", wrap_dn_cnt, m_wd);
        chk("overflow", overflow, m_ov);
    endtask

    task automatic step(input int c, input bit r);
        count = c[3:0];
        evt_if.evt_ready = r;
        @(posedge clk);
        model_edge(c, r);
        #1;
        check_all();
    endtask

    task automatic cstep(input bit up);
        if (up) cval = (cval >= M) ? 0 : cval + 1;
        else    cval = (cval == 0 || cval > M) ? M : cval - 1;
        step(cval, 1'b1);
    endtask

    task automatic do_reset();
        count = 4'd0;
        reset = 1'b1;
        #1;
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_wu", wrap_up_cnt, 0);
        chk("rst_wd", wrap_dn_cnt, 0);
        chk("rst_ov", overflow, 0);
        chk("rst_state", dut.state, INIT);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int v;
        bit dirv;
        bit rdy;
        int r;
        reset = 1'b1;
        count = 4'd0;
        evt_if.evt_ready = 1'b1;
        #1;
        do_reset();

        // Count up through a full loop: single WRAP_UP at value 0.
        step(0, 1'b1);
        for (int i = 0; i < 11; i++) cstep(1'b1);
        chk("wrapup_type", evt_if.evt_type, 0);
        chk("wrapup_value", evt_if.evt_value, 0);
        chk("wrapup_cnt", wrap_up_cnt, 1);
        step(1, 1'b1);
        chk("wrapup_one_event", n_popped, 1);

        // Up to 4 then down: DIR_CHANGE at 3.
        do_reset();
        step(0, 1'b1);
        for (int i = 0; i < 4; i++) cstep(1'b1);
        cstep(1'b0);
        chk("dirchg_type", evt_if.evt_type, 2);
        chk("dirchg_value", evt_if.evt_value, 3);

        // Count down from reset: WRAP_DOWN at MAX.
        do_reset();
        step(0, 1'b1);
        cstep(1'b0);
        chk("wrapdn_type", evt_if.evt_type, 1);
        chk("wrapdn_value", evt_if.evt_value, M);
        chk("wrapdn_cnt", wrap_dn_cnt, 1);

        // Illegal jumps.
        do_reset();
        step(2, 1'b1);
        step(5, 1'b1);
        chk("ill5_type", evt_if.evt_type, 3);
        chk("ill5_value", evt_if.evt_value, 5);
        chk("ill5_state", dut.state, ARMED);
        step(12, 1'b1);
        chk("ill12_type", evt_if.evt_type, 3);
        chk("ill12_value", evt_if.evt_value, 12);
        chk("ill12_state", dut.state, ARMED);

        // Five events against a stalled consumer: four kept, overflow.
        do_reset();
        step(2, 1'b0);
        step(7, 1'b0);
        step(3, 1'b0);
        step(9, 1'b0);
        step(1, 1'b0);
        step(5, 1'b0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", evt_if.evt_value, 7);
        step(6, 1'b1);
        chk("drain1", evt_if.evt_value, 3);
        step(7, 1'b1);
        chk("drain2", evt_if.evt_value, 9);
        step(8, 1'b1);
        chk("drain3", evt_if.evt_value, 1);
        step(9, 1'b1);
        chk("drain_empty", evt_if.evt_valid, 0);

        // Reset with queued events, then first edge is a capture.
        do_reset();
        step(2, 1'b0);
        step(7, 1'b0);
        step(3, 1'b0);
        chk("pre_rst_valid", evt_if.evt_valid, 1);
        do_reset();
        step(4, 1'b1);
        chk("post_rst_noevt", evt_if.evt_valid, 0);

        // Wrap counter saturation.
        do_reset();
        step(0, 1'b1);
        for (int i = 0; i < 260 * 11; i++) cstep(1'b1);
        chk("wu_saturated", wrap_up_cnt, 255);

        // Random walk with random backpressure.
        do_reset();
        v = 0;
        dirv = 1'b1;
        step(0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 3) != 0);
            if (r == 6 || r == 7) dirv = !dirv;
            if (r <= 7) begin
                if (v > M) v = $urandom_range(0, M);
                else if (dirv) v = (v == M) ? 0 : v + 1;
                else v = (v == 0) ? M : v - 1;
            end else if (r == 9) begin
                v = $urandom_range(0, 15);
            end
            step(v, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter N, default 4, width of the observed count bus.
REQ-002 Parameter MAX_VALUE, default 10, wrap limit of the observed up/down looping counter; legal range 2..2^N-1.
REQ-003 Parameter DEPTH, default 4, event FIFO depth; power of two, >=2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count  input  N  value of the upstream looping up/down counter, sampled every clk.
REQ-007 evt_valid  output  1  FIFO head holds an event.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_type  output  2  head event type: 0 WRAP_UP, 1 WRAP_DOWN, 2 DIR_CHANGE, 3 ILLEGAL.
REQ-010 evt_value  output  N  count value that caused the head event.
REQ-011 wrap_up_cnt  output  8  saturating count of WRAP_UP detections.
REQ-012 wrap_dn_cnt  output  8  saturating count of WRAP_DOWN detections.
REQ-013 overflow  output  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-014 State machine: INIT (no previous sample), ARMED (previous sample held, direction unknown), TRACK (previous sample and direction known).
REQ-015 INIT: capture count into prev on the next edge, go to ARMED; no event is generated.
REQ-016 ARMED/TRACK: each edge classify (prev, count): UP = count==prev+1 with prev<MAX_VALUE; DOWN = count==prev-1 with prev>0; WRAP_UP = prev==MAX_VALUE and count==0; WRAP_DOWN = prev==0 and count==MAX_VALUE; anything else is ILLEGAL, including hold (count==prev) and count>MAX_VALUE.
REQ-017 Direction: UP and WRAP_UP imply up; DOWN and WRAP_DOWN imply down; ARMED moves to TRACK on the first legal step.
REQ-018 In TRACK, a legal step whose direction differs from the stored direction is a DIR_CHANGE.
REQ-019 At most one event per edge; priority ILLEGAL > WRAP_UP/WRAP_DOWN > DIR_CHANGE; stored direction always updates on a legal step.
REQ-020 ILLEGAL: enqueue event, return to ARMED (direction forgotten), prev takes count.
REQ-021 prev takes count on every edge outside reset.
REQ-022 Latency: event is written on the edge that samples the offending count; evt_valid rises after that same edge if the FIFO was empty.
REQ-023 FIFO is first-word-fall-through; pop occurs when evt_valid and evt_ready are both high.
REQ-024 Push while full with no pop on that edge: event dropped, overflow set, counters still update.
REQ-025 Push while full with simultaneous pop: push accepted, no overflow.
REQ-026 Pop while empty has no effect; evt_type/evt_value are don't-care when evt_valid is low.
REQ-027 wrap_up_cnt/wrap_dn_cnt increment on their detection regardless of FIFO state; hold at 255.

Reset
REQ-028 Reset forces state INIT, prev 0, direction up, FIFO empty, evt_valid 0, wrap_up_cnt 0, wrap_dn_cnt 0, overflow 0, asynchronously.
REQ-029 Reset mid-operation discards queued events; the first post-reset edge is an INIT capture.

Structure
REQ-030 Shared package count_mon_pkg holds the evt_type enum (WRAP_UP, WRAP_DOWN, DIR_CHANGE, ILLEGAL) and the monitor state enum (INIT, ARMED, TRACK).
REQ-031 Event storage is a sub-module count_evt_fifo (parameters WIDTH, DEPTH; push/pop/full/empty; asynchronous active-high reset).

Verification (N=4, MAX_VALUE=10, DEPTH=4, counter instance driving count, evt_ready=1 unless noted)
REQ-032 up_down=1 for 12 cycles from reset (0..10,0) -> exactly one event WRAP_UP value 0; wrap_up_cnt=1.
REQ-033 up_down=1 to 3, 4, then up_down=0 -> one DIR_CHANGE value 3.
REQ-034 up_down=0 from reset (0->10) -> WRAP_DOWN value 10; wrap_dn_cnt=1.
REQ-035 Standalone, drive count 2 then 5, then 12 -> ILLEGAL value 5, then ILLEGAL value 12; state ARMED after each.
REQ-036 evt_ready=0, produce 5 events -> 4 queued, overflow=1, 5th lost; evt_ready=1 drains the 4 in order.
REQ-037 Assert reset with 2 events queued -> evt_valid=0, counters 0, overflow 0 immediately; the next count change produces no event.
